sram_array_ctrl: RTL
====================

SRAM_ARRAY_CTRL -- requirements
Module: sram_array_ctrl

Interface
REQ-001 SHALL have parameter: WR_CYCLES, 2, cycles write_en is held high per write (legal 1..15).
REQ-002 SHALL have ports, in this order:
- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  12  byte address, 0x000..0xFFF.
- req_wdata  input  8  write data.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  8  read data, valid with rsp_valid.
- rsp_err  output  1  write-verify mismatch, valid with rsp_valid.
- sram_write_en  output  1  array write enable, active high.
- sram_sense_en  output  1  array sense enable, active low.
- sram_addr  output  12  array address; bit i drives addr<i>.
- sram_din  output  8  array data in; bit i drives din<i>.
- sram_dout  input  8  array data out; bit i is dout<i>.

Function
REQ-003 SHALL be a single FSM with states IDLE, WRITE, SETUP, SENSE, CAPTURE, RECOVER.
REQ-004 SHALL drive req_ready = 1 only in IDLE and never while reset is high.
REQ-005 SHALL accept a request on an edge where req_valid && req_ready are both high, and latch req_we, req_addr and req_wdata into sram_addr and sram_din at that edge.
REQ-006 SHALL hold sram_addr and sram_din stable from accept until the FSM next returns to IDLE.
REQ-007 SHALL route IDLE→WRITE on an accepted write and IDLE→SETUP on an accepted read.
REQ-008 SHALL have WRITE assert sram_write_en for exactly WR_CYCLES consecutive cycles, counted by a 4-bit counter, then move to RECOVER; with the verify option, WRITE moves to SETUP instead.
REQ-009 SHALL have SETUP last 1 cycle with both enables inactive (write_en 0, sense_en 1), then move to SENSE.
REQ-010 SHALL have SENSE last 1 cycle with sram_sense_en = 0, then move to CAPTURE.
REQ-011 SHALL have CAPTURE last 1 cycle with sense_en = 1 and register sram_dout at its closing edge, then move to IDLE.
REQ-012 SHALL have RECOVER last 1 cycle with both enables inactive, then move to IDLE.
REQ-013 SHALL never assert sram_write_en and sense_en = 0 in the same cycle.
REQ-014 SHALL pulse rsp_valid high for exactly one cycle: the first IDLE cycle after CAPTURE or RECOVER.
REQ-015 SHALL give these latencies, counted from the accept edge to the rsp_valid cycle:
- read: 4 cycles.
- write without verify: WR_CYCLES+2 cycles.
- write with verify: WR_CYCLES+4 cycles.
REQ-016 SHALL permit a new accept in the same cycle as rsp_valid (back-to-back, with no idle gap required).
REQ-017 SHALL drive rsp_rdata = captured dout after a read, and = sram_din after a write; rsp_err = 0 unless REQ-022 applies.
REQ-018 SHALL treat all 12-bit addresses equally, with no wrap or bounds logic; 0xFFF is legal.
REQ-019 SHALL ignore req_* inputs while req_ready = 0, with no queuing.

Reset
REQ-020 SHALL, while reset is high at an edge, force:
- state IDLE.
- sram_write_en = 0 and sram_sense_en = 1.
- sram_addr = 0 and sram_din = 0.
- rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- the WRITE counter to 0.
REQ-021 SHALL abort any operation in progress when reset is asserted mid-operation, producing no rsp_valid for it; enables are inactive in the cycle after the reset edge.

Configuration
REQ-022 SHALL, when SRAM_CTRL_WRITE_VERIFY_EN is defined, follow every write with SETUP/SENSE/CAPTURE at the same address and set rsp_err = (captured dout != sram_din), with rsp_rdata = captured dout.
REQ-023 SHALL, when SRAM_CTRL_WRITE_VERIFY_EN is undefined, omit the verify path and tie rsp_err to 0.

Verification
REQ-024 Write 0x5A to 0x123, WR_CYCLES=2 -> write_en high exactly 2 cycles, addr 0x123 / din 0x5A stable throughout, rsp_valid 4 cycles after accept.
REQ-025 Read 0x123 after REQ-024 -> sense_en low exactly 1 cycle (cycle 2 after accept), rsp_valid 4 cycles after accept, rsp_rdata = 0x5A.
REQ-026 Back-to-back: write 0xFF to 0xFFF, then read 0xFFF presented with req_valid held -> second accept in the rsp_valid cycle, rsp_rdata = 0xFF, address wrap never seen.
REQ-027 Assert reset in the second WRITE cycle -> write_en 0 and req_ready 1 the next cycle, no rsp_valid, outputs at reset values.
REQ-028 Verify macro defined, with the array model forced to return 0x00 for a 0xA5 write -> rsp_valid WR_CYCLES+4 cycles after accept, rsp_err = 1, rsp_rdata = 0x00; a matching write gives rsp_err = 0.
REQ-029 100 random write/read pairs against a reference memory -> every rsp_rdata matches, and write_en/sense_en never overlap.

Source files
------------

// File: rtl/sram_array_ctrl.sv
// -----------------------------------------------------------------------------
// sram_array_ctrl
//
// Sequences single read and write operations onto a raw SRAM macro. Each
// operation is accepted from a valid/ready request port, then driven onto the
// array's write enable (active high) and sense enable (active low). Each
// operation completes with a one-cycle response pulse.
//
// Optional feature macro: SRAM_CTRL_WRITE_VERIFY_EN
//   When defined, every write is followed by a read-back of the same address.
//   rsp_err then flags a mismatch between the read-back and the written byte.
//   When undefined, rsp_err is tied low.
//
// Parameters
//   WR_CYCLES      cycles sram_write_en is held per write (1..15)
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   req_valid      request present
//   req_ready      controller idle and able to accept
//   req_we         1 = write, 0 = read
//   req_addr       12-bit byte address
//   req_wdata      write data
//   rsp_valid      one-cycle completion pulse
//   rsp_rdata      read data (captured dout for reads, written data for writes)
//   rsp_err        write-verify mismatch
//   sram_write_en  array write enable, active high
//   sram_sense_en  array sense enable, active low
//   sram_addr      array address, held for the whole operation
//   sram_din       array data in, held for the whole operation
//   sram_dout      array data out
// -----------------------------------------------------------------------------
module sram_array_ctrl #(
  parameter int unsigned WR_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [11:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        sram_write_en,
  output logic        sram_sense_en,
  output logic [11:0] sram_addr,
  output logic [7:0]  sram_din,
  input  logic [7:0]  sram_dout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    SETUP   = 3'd2,
    SENSE   = 3'd3,
    CAPTURE = 3'd4,
    RECOVER = 3'd5
  } state_t;

  // Terminal count of the write-pulse counter.
  localparam logic [3:0] WR_LAST = 4'(WR_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_wr_cnt;
  logic [3:0]  w_wr_cnt_next;
  logic [11:0] r_addr;
  logic [7:0]  r_din;
  logic        r_write_en;
  logic        r_sense_en;
  logic        r_rsp_valid;
  logic [7:0]  r_rdata;
  logic        w_accept;

`ifdef SRAM_CTRL_WRITE_VERIFY_EN
  logic        r_we;
  logic        r_err;
`endif

  // Ready is gated by reset directly so no request can slip in on a reset edge.
  assign req_ready = (r_state == IDLE) && !reset;
  assign w_accept  = req_valid && req_ready;

  // Next-state logic.
  always_comb begin
    w_state_next  = r_state;
    w_wr_cnt_next = r_wr_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = req_we ? WRITE : SETUP;
        end
      end
      WRITE: begin
        if (r_wr_cnt == WR_LAST) begin
          w_wr_cnt_next = 4'd0;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
          w_state_next  = SETUP;
`else
          w_state_next  = RECOVER;
`endif
        end else begin
          w_wr_cnt_next = r_wr_cnt + 4'd1;
        end
      end
      SETUP:   w_state_next = SENSE;
      SENSE:   w_state_next = CAPTURE;
      CAPTURE: w_state_next = IDLE;
      RECOVER: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_wr_cnt    <= 4'd0;
      r_addr      <= 12'd0;
      r_din       <= 8'd0;
      r_write_en  <= 1'b0;
      r_sense_en  <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 8'd0;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
      r_we        <= 1'b0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_wr_cnt <= w_wr_cnt_next;

      // Enables are registered from the next state so the array pins are
      // glitch-free yet still line up exactly with the state they belong to.
      // Write and sense are decoded from mutually exclusive states, so
      // they can never overlap.
      r_write_en <= (w_state_next == WRITE);
      r_sense_en <= (w_state_next != SENSE);

      // Response fires in the first IDLE cycle after an operation closes.
      r_rsp_valid <= (r_state == CAPTURE) || (r_state == RECOVER);

      if (w_accept) begin
        r_addr <= req_addr;
        r_din  <= req_wdata;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
        r_we   <= req_we;
`endif
      end

      if (r_state == CAPTURE) begin
        r_rdata <= sram_dout;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
        r_err   <= r_we && (sram_dout != r_din);
`endif
      end else if (r_state == RECOVER) begin
        r_rdata <= r_din;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
        r_err   <= 1'b0;
`endif
      end
    end
  end

  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rdata;
  assign sram_write_en = r_write_en;
  assign sram_sense_en = r_sense_en;
  assign sram_addr     = r_addr;
  assign sram_din      = r_din;

`ifdef SRAM_CTRL_WRITE_VERIFY_EN
  assign rsp_err = r_err;
`else
  assign rsp_err = 1'b0;
`endif

endmodule
